// File: rtl/led_pio_sequencer_if.sv
// rtl/led_pio_sequencer_if.sv - Avalon-MM bus bundle shared by the CSR slave port and the PIO master port
interface led_pio_sequencer_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/led_pio_sequencer.sv
// rtl/led_pio_sequencer.sv - LED pattern sequencer driving a PIO over Avalon-MM; optional readback check via LED_SEQ_READBACK_EN
module led_pio_sequencer #(
    parameter int DEPTH = 8,
    parameter int LED_W = 8,
    parameter int PER_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    led_pio_sequencer_if.slave    s,
    led_pio_sequencer_if.master   m,
    output logic                  irq
);
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             run;
    logic             loop;
    logic             irq_en;
    logic             done;
    logic             err;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] cnt;
    logic [3:0]       length;
    logic [3:0]       idx;
    logic [3:0]       eff_len;
    logic [LED_W-1:0] pattern [DEPTH];
    logic [LED_W-1:0] cur_pattern;
    logic             csr_wr;
    logic             start;
    logic             load_cnt;
    logic             dec_cnt;
    logic             step_idx;
    logic             wrap_idx;
    logic             set_done;
    logic             set_err;
    logic             unused_inputs;

    assign csr_wr      = s.chipselect & ~s.write_n;
    assign eff_len     = (length == 4'd0 || length > 4'(DEPTH)) ? 4'(DEPTH) : length;
    assign cur_pattern = pattern[idx[IDX_W-1:0]];
    assign irq         = done & irq_en;
    assign m.address   = '0;
    assign s.waitrequest = 1'b0;
    assign unused_inputs = ^{s.read_n, s.writedata, m.readdata};

    // State register; async reset forces the master outputs idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state, sequencing strobes and master bus outputs
    always_comb begin
        state_next   = state;
        start        = 1'b0;
        load_cnt     = 1'b0;
        dec_cnt      = 1'b0;
        step_idx     = 1'b0;
        wrap_idx     = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        m.chipselect = 1'b0;
        m.write_n    = 1'b1;
        m.read_n     = 1'b1;
        m.writedata  = '0;
        case (state)
            ST_IDLE: begin
                if (csr_wr && s.address == 4'd0 && s.writedata[0]) begin
                    start      = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                m.chipselect = 1'b1;
                m.write_n    = 1'b0;
                m.writedata  = 32'(cur_pattern);
                if (!m.waitrequest) begin
`ifdef LED_SEQ_READBACK_EN
                    state_next = ST_READ;
`else
                    if (run) begin
                        state_next = ST_WAIT;
                        load_cnt   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
`endif
                end
            end
`ifdef LED_SEQ_READBACK_EN
            ST_READ: begin
                m.chipselect = 1'b1;
                m.read_n     = 1'b0;
                if (!m.waitrequest) begin
                    if (m.readdata[LED_W-1:0] != cur_pattern) begin
                        set_err    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (run) begin
                        state_next = ST_WAIT;
                        load_cnt   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
`endif
            ST_WAIT: begin
                if (!run) begin
                    state_next = ST_IDLE;
                end else if (cnt == '0) begin
                    if (idx < eff_len - 4'd1) begin
                        step_idx   = 1'b1;
                        state_next = ST_WRITE;
                    end else if (loop) begin
                        wrap_idx   = 1'b1;
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            ST_DONE: begin
                set_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Step index and inter-write period counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            cnt <= '0;
        end else begin
            if (start || wrap_idx) idx <= '0;
            else if (step_idx)     idx <= idx + 4'd1;
            if (load_cnt)          cnt <= period;
            else if (dec_cnt)      cnt <= cnt - 1'b1;
        end
    end

    // CSR registers and pattern table; a CPU STATUS write beats a same-cycle DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            loop   <= 1'b0;
            irq_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            period <= '0;
            length <= '0;
            for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        end else begin
            if (csr_wr) begin
                case (s.address)
                    4'd0: begin
                        run    <= s.writedata[0];
                        loop   <= s.writedata[1];
                        irq_en <= s.writedata[2];
                    end
                    4'd2: period <= s.writedata[PER_W-1:0];
                    4'd3: length <= s.writedata[3:0];
                    default: ;
                endcase
                if (s.address[3] && {1'b0, s.address[2:0]} < 4'(DEPTH))
                    pattern[s.address[IDX_W-1:0]] <= s.writedata[LED_W-1:0];
            end
            if (set_done || set_err) run <= 1'b0;
            if (start) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (set_done) done <= 1'b1;
            if (set_err)  err  <= 1'b1;
            if (csr_wr && s.address == 4'd1) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

    // Zero-wait-state CSR read mux
    always_comb begin
        s.readdata = '0;
        case (s.address)
            4'd0: s.readdata[2:0] = {irq_en, loop, run};
            4'd1: s.readdata[2:0] = {err, done, state != ST_IDLE};
            4'd2: s.readdata[PER_W-1:0] = period;
            4'd3: s.readdata[3:0] = length;
            default: begin
                if (s.address[3] && {1'b0, s.address[2:0]} < 4'(DEPTH))
                    s.readdata[LED_W-1:0] = pattern[s.address[IDX_W-1:0]];
            end
        endcase
    end
endmodule

// File: tb/tb_led_pio_sequencer.sv
// tb/tb_led_pio_sequencer.sv - self-checking bench for led_pio_sequencer with a PIO slave model and sequence reference model
`timescale 1ns/1ps
module tb_led_pio_sequencer;
`ifdef LED_SEQ_READBACK_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic irq;
    always #5 clk = ~clk;

    led_pio_sequencer_if #(.ADDR_W(4)) s_if ();
    led_pio_sequencer_if #(.ADDR_W(2)) m_if ();

    led_pio_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s_if),
        .m       (m_if),
        .irq     (irq)
    );

    int total = 0;
    int bad = 0;
    int cycle = 0;

    logic [7:0] wr_data_q [$];
    int         wr_start_q [$];
    int         wr_acc_q [$];
    int         stall_q [$];
    logic [7:0] tbl [8];
    bit         force_bad_read = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // PIO slave model: inserts planned stalls, records accepted writes, checks held signals
    initial begin
        bit          in_prog;
        int          stall_left;
        int          cur_start;
        logic [31:0] hold_data;
        logic [7:0]  pio_reg;
        in_prog = 0;
        stall_left = 0;
        cur_start = 0;
        hold_data = '0;
        pio_reg = '0;
        m_if.waitrequest = 1'b0;
        m_if.readdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_prog = 0;
                m_if.waitrequest = 1'b0;
                pio_reg = '0;
            end else if (m_if.chipselect === 1'b1 && m_if.write_n === 1'b0) begin
                if (!in_prog) begin
                    in_prog = 1;
                    hold_data = m_if.writedata;
                    cur_start = cycle;
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    check("wr_address", 32'(m_if.address), 32'd0);
                end else begin
                    check("stall_hold_data", m_if.writedata, hold_data);
                    check("stall_hold_addr", 32'(m_if.address), 32'd0);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    m_if.waitrequest = 1'b1;
                end else begin
                    m_if.waitrequest = 1'b0;
                    in_prog = 0;
                    wr_data_q.push_back(m_if.writedata[7:0]);
                    wr_start_q.push_back(cur_start);
                    wr_acc_q.push_back(cycle + 1);
                    pio_reg = m_if.writedata[7:0];
                    check("wr_upper_zero", {8'd0, m_if.writedata[31:8]}, 32'd0);
                end
            end else begin
                if (in_prog) begin
                    check("stall_write_n", {31'd0, m_if.write_n}, 32'd0);
                    in_prog = 0;
                end
                m_if.waitrequest = 1'b0;
                m_if.readdata = force_bad_read ? 32'd0 : {24'd0, pio_reg};
            end
        end
    end

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_if.address = a;
        s_if.writedata = d;
        s_if.chipselect = 1'b1;
        s_if.write_n = 1'b0;
        @(posedge clk);
        #1;
        s_if.chipselect = 1'b0;
        s_if.write_n = 1'b1;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_if.address = a;
        s_if.read_n = 1'b0;
        #1;
        d = s_if.readdata;
        s_if.read_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int n;
        n = 0;
        csr_rd(4'd1, st);
        while (st[0] && n < budget) begin
            csr_rd(4'd1, st);
            n++;
        end
        check("idle_reached", {31'd0, st[0]}, 32'd0);
    endtask

    task automatic program_regs(input int len, input int per);
        for (int i = 0; i < 8; i++) csr_wr(4'(8 + i), {24'd0, tbl[i]});
        csr_wr(4'd2, per);
        csr_wr(4'd3, len);
    endtask

    task automatic clear_capture();
        wr_data_q.delete();
        wr_start_q.delete();
        wr_acc_q.delete();
        stall_q.delete();
    endtask

    // Single-shot run compared against the expected step list derived from table/length/period
    task automatic run_seq(input int len, input int per, input bit ie, input int stall_max);
        int          exp_len;
        int          k;
        int          n;
        logic [31:0] st;
        logic [31:0] ctrl;
        exp_len = (len == 0 || len > 8) ? 8 : len;
        program_regs(len, per);
        clear_capture();
        for (int i = 0; i < 8; i++)
            stall_q.push_back(stall_max > 0 ? int'($urandom_range(0, stall_max)) : 0);
        csr_wr(4'd0, {29'd0, ie, 1'b0, 1'b1});
        k = cycle;
        wait_idle(400);
        check("n_writes", wr_data_q.size(), exp_len);
        n = (wr_data_q.size() < exp_len) ? wr_data_q.size() : exp_len;
        if (n > 0) check("first_latency", wr_start_q[0], k);
        for (int i = 0; i < n; i++) begin
            check("wr_data", {24'd0, wr_data_q[i]}, {24'd0, tbl[i]});
            if (i > 0) check("spacing", wr_start_q[i] - wr_acc_q[i-1], per + GAP);
        end
        csr_rd(4'd1, st);
        check("status_done", st, 32'h2);
        check("irq_level", {31'd0, irq}, {31'd0, ie});
        csr_rd(4'd0, ctrl);
        check("ctrl_run_cleared", ctrl, {29'd0, ie, 2'b00});
        csr_wr(4'd1, 32'd0);
        csr_rd(4'd1, st);
        check("status_cleared", st, 32'h0);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        stall_q.delete();
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        int          n_clear;
        reset_n = 1'b0;
        s_if.address = '0;
        s_if.chipselect = 1'b0;
        s_if.write_n = 1'b1;
        s_if.read_n = 1'b1;
        s_if.writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_cs", {31'd0, m_if.chipselect}, 32'd0);
        check("rst_m_write_n", {31'd0, m_if.write_n}, 32'd1);
        check("rst_m_read_n", {31'd0, m_if.read_n}, 32'd1);
        check("rst_m_wdata", m_if.writedata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        csr_rd(4'd0, rd);  check("rst_ctrl", rd, 32'd0);
        csr_rd(4'd1, rd);  check("rst_status", rd, 32'd0);
        csr_rd(4'd2, rd);  check("rst_period", rd, 32'd0);
        csr_rd(4'd8, rd);  check("rst_table0", rd, 32'd0);
        csr_rd(4'd5, rd);  check("unmapped_zero", rd, 32'd0);

        // T1: three steps, period 4, IRQ enabled
        tbl = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
        run_seq(3, 4, 1'b1, 0);
        // T3: 5-cycle stall on step 1
        tbl = '{8'h3C, 8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        program_regs(3, 2);
        clear_capture();
        stall_q.push_back(0); stall_q.push_back(5); stall_q.push_back(0);
        csr_wr(4'd0, 32'h1);
        wait_idle(200);
        check("t3_n_writes", wr_data_q.size(), 3);
        if (wr_data_q.size() == 3) begin
            check("t3_stall_len", wr_acc_q[1] - wr_start_q[1], 6);
            check("t3_spacing", wr_start_q[2] - wr_acc_q[1], 2 + GAP);
            check("t3_data1", {24'd0, wr_data_q[1]}, 32'hC3);
        end
        csr_wr(4'd1, 32'd0);
        // T4: LENGTH 0 and 12 both mean full depth
        for (int i = 0; i < 8; i++) tbl[i] = 8'($urandom);
        run_seq(0, 1, 1'b0, 0);
        run_seq(12, 0, 1'b1, 1);
        // Randomized single-shot runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) tbl[i] = 8'($urandom);
            run_seq($urandom_range(0, 15), $urandom_range(0, 5), 1'($urandom), 3);
        end

        // T2: looping two-step pattern, period 0, then RUN cleared
        tbl = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        program_regs(2, 0);
        clear_capture();
        csr_wr(4'd0, 32'h3);
        n = 0;
        while (wr_data_q.size() < 8 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t2_progress", {31'd0, wr_data_q.size() >= 8}, 32'd1);
        csr_wr(4'd0, 32'h0);
        n_clear = wr_data_q.size();
        wait_idle(50);
        repeat (10) @(negedge clk);
        check("t2_stop", {31'd0, wr_data_q.size() <= n_clear + 1}, 32'd1);
        for (int i = 0; i < wr_data_q.size(); i++) begin
            check("t2_data", {24'd0, wr_data_q[i]}, {24'd0, tbl[i % 2]});
            if (i > 0) check("t2_spacing", wr_start_q[i] - wr_acc_q[i-1], GAP);
        end
        csr_rd(4'd1, rd);
        check("t2_no_done", rd, 32'd0);

        // T2b: RUN cleared while waiting out a long period -> no further writes
        program_regs(2, 20);
        clear_capture();
        csr_wr(4'd0, 32'h3);
        n = 0;
        while (wr_data_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        csr_wr(4'd0, 32'h0);
        repeat (40) @(negedge clk);
        check("t2b_single_write", wr_data_q.size(), 1);
        csr_rd(4'd1, rd);
        check("t2b_status", rd, 32'd0);

        // T5: async reset while a write is stalled
        program_regs(4, 3);
        clear_capture();
        stall_q.push_back(10);
        csr_wr(4'd0, 32'h1);
        n = 0;
        while (m_if.chipselect !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_in_write", {31'd0, m_if.chipselect}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_cs", {31'd0, m_if.chipselect}, 32'd0);
        check("t5_write_n", {31'd0, m_if.write_n}, 32'd1);
        check("t5_wdata", m_if.writedata, 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        clear_capture();
        csr_rd(4'd9, rd);  check("t5_table_cleared", rd, 32'd0);
        csr_rd(4'd1, rd);  check("t5_status", rd, 32'd0);
        repeat (20) @(negedge clk);
        check("t5_no_writes", wr_data_q.size(), 0);

`ifdef LED_SEQ_READBACK_EN
        // T6: readback mismatch raises ERR and stops
        tbl = '{8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        program_regs(2, 1);
        clear_capture();
        force_bad_read = 1;
        csr_wr(4'd0, 32'h1);
        wait_idle(50);
        force_bad_read = 0;
        check("t6_n_writes", wr_data_q.size(), 1);
        csr_rd(4'd1, rd);  check("t6_err", rd, 32'h4);
        csr_rd(4'd0, rd);  check("t6_run_cleared", rd, 32'd0);
        csr_wr(4'd1, 32'd0);
        csr_rd(4'd1, rd);  check("t6_err_cleared", rd, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
